// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - lamp codes, phase enum and phase helpers for the intersection controller
package traffic_pkg;

  localparam logic [1:0] LAMP_OFF    = 2'd0;
  localparam logic [1:0] LAMP_GREEN  = 2'd1;
  localparam logic [1:0] LAMP_YELLOW = 2'd2;
  localparam logic [1:0] LAMP_RED    = 2'd3;

  typedef enum logic [2:0] {
    A_GREEN  = 3'd0,
    A_YELLOW = 3'd1,
    CLEAR_AB = 3'd2,
    B_GREEN  = 3'd3,
    B_YELLOW = 3'd4,
    CLEAR_BA = 3'd5
  } phase_e;

  function automatic int phase_dur(input phase_e ph, input int green_a, input int green_b,
                                   input int yellow, input int clear);
    int d;
    case (ph)
      A_GREEN:            d = green_a;
      A_YELLOW, B_YELLOW: d = yellow;
      B_GREEN:            d = green_b;
      CLEAR_AB, CLEAR_BA: d = clear;
      default:            d = 1;
    endcase
    return d;
  endfunction

  function automatic phase_e next_phase(input phase_e ph);
    phase_e n;
    case (ph)
      A_GREEN:  n = A_YELLOW;
      A_YELLOW: n = CLEAR_AB;
      CLEAR_AB: n = B_GREEN;
      B_GREEN:  n = B_YELLOW;
      B_YELLOW: n = CLEAR_BA;
      default:  n = A_GREEN;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// rtl/tl_phase_timer.sv - tick-enabled phase counter with synchronous clear and terminal-count flag
module tl_phase_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             clear,
  input  logic [CNT_W-1:0] term_val,
  output logic [CNT_W-1:0] count,
  output logic             term
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tick) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign term  = (count_q == term_val);

endmodule

// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - two-approach intersection controller with all-red clearance
// Optional pedestrian request / walk feature enabled by defining PED_REQ_EN.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int GREEN_A_T   = 25,
  parameter int GREEN_B_T   = 10,
  parameter int YELLOW_T    = 3,
  parameter int CLEAR_T     = 1,
  parameter int MIN_GREEN_T = 8,
  parameter int CNT_W       = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
`ifdef PED_REQ_EN
  input  logic             ped_req,
  output logic             walk,
`endif
  output logic [1:0]       light_a,
  output logic [1:0]       light_b,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] count
);

  phase_e           state_q, state_d;
  logic [CNT_W-1:0] term_val;
  logic             term;
  logic             illegal;
  logic             advance;
  logic             clear;
  logic             ped_pend;
  logic             early_exit;

  assign term_val = CNT_W'(phase_dur(state_q, GREEN_A_T, GREEN_B_T, YELLOW_T, CLEAR_T) - 1);
  assign illegal  = (3'(state_q) > 3'd5);

  // A pending pedestrian request cuts A green short once the minimum has elapsed.
  assign early_exit = (state_q == A_GREEN) && ped_pend && (count >= CNT_W'(MIN_GREEN_T - 1));
  assign advance    = tick && !illegal && (term || early_exit);
  assign clear      = illegal || advance;

  tl_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .clear   (clear),
    .term_val(term_val),
    .count   (count),
    .term    (term)
  );

  always_comb begin
    state_d = state_q;
    if (illegal) begin
      state_d = CLEAR_BA;
    end else if (advance) begin
      state_d = next_phase(state_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR_BA;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    light_a = LAMP_RED;
    light_b = LAMP_RED;
    case (state_q)
      A_GREEN:  light_a = LAMP_GREEN;
      A_YELLOW: light_a = LAMP_YELLOW;
      B_GREEN:  light_b = LAMP_GREEN;
      B_YELLOW: light_b = LAMP_YELLOW;
      default: begin
        light_a = LAMP_RED;
        light_b = LAMP_RED;
      end
    endcase
  end

  assign state = state_q;

`ifdef PED_REQ_EN
  logic ped_pend_q, ped_pend_d;
  logic walk_q, walk_d;
  logic enter_b, leave_b;

  assign enter_b = advance && (state_q == CLEAR_AB);
  assign leave_b = advance && (state_q == B_GREEN);

  // A request landing on the B-green entry edge survives into the next cycle.
  always_comb begin
    ped_pend_d = ped_pend_q | ped_req;
    walk_d     = walk_q;
    if (enter_b) begin
      ped_pend_d = ped_req;
      walk_d     = ped_pend_q;
    end else if (leave_b || illegal) begin
      walk_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ped_pend_q <= 1'b0;
      walk_q     <= 1'b0;
    end else begin
      ped_pend_q <= ped_pend_d;
      walk_q     <= walk_d;
    end
  end

  assign ped_pend = ped_pend_q;
  assign walk     = walk_q;
`else
  assign ped_pend = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb/tb_traffic_light_ctrl.sv - self-checking bench for traffic_light_ctrl (optionally with PED_REQ_EN)
module tb_traffic_light_ctrl;
  import traffic_pkg::*;

  localparam int CNT_W = 6;
`ifdef PED_REQ_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             tick;
  logic             ped_req;
  logic             walk;
  logic [1:0]       light_a, light_b;
  logic [2:0]       state;
  logic [CNT_W-1:0] count;

  traffic_light_ctrl #(
    .GREEN_A_T(25), .GREEN_B_T(10), .YELLOW_T(3), .CLEAR_T(1), .MIN_GREEN_T(8), .CNT_W(CNT_W)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
`ifdef PED_REQ_EN
    .ped_req(ped_req),
    .walk   (walk),
`endif
    .light_a(light_a),
    .light_b(light_b),
    .state  (state),
    .count  (count)
  );

`ifndef PED_REQ_EN
  assign walk = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int cnt;
    int la;
    int lb;
    int wk;
  } exp_t;

  typedef struct {
    int code;
    int dur;
    int la;
    int lb;
  } phase_vec_t;

  exp_t       exp_q[$];
  phase_vec_t tbl[6];
  int errors = 0;
  int checks = 0;
  int m_state, m_count;
  bit m_pend, m_walk;

  function automatic int m_dur(input int s);
    case (s)
      0: return 25;
      1: return 3;
      2: return 1;
      3: return 10;
      4: return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int m_la(input int s);
    return (s == 0) ? 1 : (s == 1) ? 2 : 3;
  endfunction

  function automatic int m_lb(input int s);
    return (s == 3) ? 1 : (s == 4) ? 2 : 3;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one clock of stimulus, predict its outcome, then compare after the edge.
  task automatic cycle(input bit t, input bit p);
    exp_t e;
    bit   adv;
    int   prev;
    tick    = t;
    ped_req = p;
    prev    = m_state;
    adv     = 1'b0;
    if (t) begin
      if (m_count == m_dur(m_state) - 1 || (PED && m_state == 0 && m_pend && m_count >= 7))
        adv = 1'b1;
      else
        m_count++;
    end
    if (adv) begin
      m_state = (m_state + 1) % 6;
      m_count = 0;
    end
    if (adv && prev == 3) m_walk = 1'b0;
    if (adv && prev == 2) begin
      m_walk = m_pend;
      m_pend = p;
    end else begin
      m_pend = m_pend | p;
    end
    e.st  = m_state;
    e.cnt = m_count;
    e.la  = m_la(m_state);
    e.lb  = m_lb(m_state);
    e.wk  = (PED && m_walk && m_state == 3) ? 1 : 0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("state", int'(state), e.st);
    chk("count", int'(count), e.cnt);
    chk("light_a", int'(light_a), e.la);
    chk("light_b", int'(light_b), e.lb);
    chk("walk", int'(walk), e.wk);
  endtask

  task automatic do_reset(input string name);
    reset   = 1'b1;
    tick    = 1'b0;
    ped_req = 1'b0;
    #1;
    chk({name, "_state"}, int'(state), 5);
    chk({name, "_count"}, int'(count), 0);
    chk({name, "_light_a"}, int'(light_a), 3);
    chk({name, "_light_b"}, int'(light_b), 3);
    chk({name, "_walk"}, int'(walk), 0);
    m_state = 5;
    m_count = 0;
    m_pend  = 1'b0;
    m_walk  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int n, total, last;
    tbl[0] = '{code: 0, dur: 25, la: 1, lb: 3};
    tbl[1] = '{code: 1, dur: 3,  la: 2, lb: 3};
    tbl[2] = '{code: 2, dur: 1,  la: 3, lb: 3};
    tbl[3] = '{code: 3, dur: 10, la: 3, lb: 1};
    tbl[4] = '{code: 4, dur: 3,  la: 3, lb: 2};
    tbl[5] = '{code: 5, dur: 1,  la: 3, lb: 3};

    reset   = 1'b0;
    tick    = 1'b0;
    ped_req = 1'b0;
    @(posedge clk);
    #1;
    do_reset("reset");

    // Tick every clock: clearance, then two full cycles walked against the phase table.
    cycle(1'b1, 1'b0);
    chk("first_a_green", int'(state), 0);
    for (int rep = 0; rep < 2; rep++) begin
      total = 0;
      for (int i = 0; i < 6; i++) begin
        chk("tbl_state", int'(state), tbl[i].code);
        chk("tbl_light_a", int'(light_a), tbl[i].la);
        chk("tbl_light_b", int'(light_b), tbl[i].lb);
        n = 0;
        while (int'(state) == tbl[i].code && n < 100) begin
          cycle(1'b1, 1'b0);
          n++;
        end
        chk("phase_len", n, tbl[i].dur);
        total += n;
      end
      chk("period", total, 43);
    end

    // Tick every 4th clock: A green stretches to 100 clocks, holds in between.
    n = 0;
    while (state == 3'd0 && n < 200) begin
      cycle((n % 4) == 3, 1'b0);
      n++;
    end
    chk("a_green_clocks_x4", n, 100);
    for (int k = 0; k < 80; k++) cycle((k % 4) == 3, 1'b0);

    // Reset mid B_YELLOW at count 1.
    n = 0;
    while (!(state == 3'd4 && count == CNT_W'(1)) && n < 100) begin
      cycle(1'b1, 1'b0);
      n++;
    end
    chk("pre_reset_state", int'(state), 4);
    do_reset("mid_reset");
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0);

    // Illegal phase code through the backdoor.
    dut.state_q = phase_e'(3'd6);
    tick = 1'b0;
    #1;
    chk("illegal_state", int'(state), 6);
    chk("illegal_light_a", int'(light_a), 3);
    chk("illegal_light_b", int'(light_b), 3);
    m_state = 5;
    m_count = 0;
    m_walk  = 1'b0;
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);

`ifdef PED_REQ_EN
    // Pulse at A green count 2: green ends after count 7; walk across all of B green.
    n = 0;
    while (!(state == 3'd0 && count == CNT_W'(2)) && n < 100) begin
      cycle(1'b1, 1'b0);
      n++;
    end
    cycle(1'b1, 1'b1);
    last = -1;
    n = 0;
    while (state == 3'd0 && n < 40) begin
      last = int'(count);
      cycle(1'b1, 1'b0);
      n++;
    end
    chk("ped_early_last_count", last, 7);
    n = 0;
    while (state != 3'd3 && n < 20) begin
      cycle(1'b1, 1'b0);
      n++;
    end
    n = 0;
    total = 0;
    while (state == 3'd3 && n < 20) begin
      if (walk) total++;
      cycle(1'b1, 1'b0);
      n++;
    end
    chk("walk_ticks", total, 10);

    // Request late in A green: next tick leaves.
    n = 0;
    while (!(state == 3'd0 && count == CNT_W'(20)) && n < 200) begin
      cycle(1'b1, 1'b0);
      n++;
    end
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    chk("ped_late_exit", int'(state), 1);
    for (int k = 0; k < 20; k++) cycle(1'b1, 1'b0);
`else
    last = 0;
    for (int k = 0; k < 20; k++) cycle(1'b1, (k % 3) == 0);
`endif

    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Parametrised two-approach intersection controller: main approach A and side approach B, each with its own green/yellow durations and an all-red clearance phase between them. A single down-stream tick enable advances the phase timer, so durations are in ticks rather than clocks. Sits between the board tick divider and the lamp-driver outputs, and replaces the fixed 42-count single-approach controller.

## Interface
Parameters:
- GREEN_A_T, 25, approach A green duration in ticks (≥1)
- GREEN_B_T, 10, approach B green duration in ticks (≥1)
- YELLOW_T, 3, yellow duration in ticks, both approaches (≥1)
- CLEAR_T, 1, all-red clearance duration in ticks (≥1)
- MIN_GREEN_T, 8, minimum A green before pedestrian early exit (1..GREEN_A_T)
- CNT_W, 6, phase counter width; must hold max(duration)−1

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- tick  in  1  single-cycle advance strobe; all timing counts ticks
- ped_req  in  1  pedestrian request, level or pulse (PED_REQ_EN only)
- light_a  out  2  approach A lamp: 0 off, 1 green, 2 yellow, 3 red
- light_b  out  2  approach B lamp, same encoding
- walk  out  1  pedestrian walk indication (PED_REQ_EN only)
- state  out  3  current phase code
- count  out  CNT_W  ticks elapsed in current phase

## Operation
- Phases in fixed order: A_GREEN(0) → A_YELLOW(1) → CLEAR_AB(2) → B_GREEN(3) → B_YELLOW(4) → CLEAR_BA(5) → A_GREEN.
- Phase durations: A_GREEN=GREEN_A_T, A_YELLOW=YELLOW_T, CLEAR_*=CLEAR_T, B_GREEN=GREEN_B_T, B_YELLOW=YELLOW_T.
- On tick: if count == duration−1, advance to the next phase and set count to 0; otherwise count+1.
- No tick: state and count hold.
- Lamp decode is combinational from state:
  - A_GREEN: A=1, B=3
  - A_YELLOW: A=2, B=3
  - B_GREEN: A=3, B=1
  - B_YELLOW: A=3, B=2
  - CLEAR_*: both 3
- Codes 6 and 7 are illegal. Both lamps read 3, and the next clock forces CLEAR_BA with count=0, tick or not.
- Never both lamps non-red; never green to green without yellow and clear.

## Timing
- Reset (async assert, sync-safe release): state=CLEAR_BA, count=0, light_a=3, light_b=3, walk=0, pending request cleared.
- The first A_GREEN starts CLEAR_T ticks after reset release.
- Registers update on the clk edge where tick=1; lamps follow state in the same cycle (zero added latency).
- Full cycle with defaults = 25+3+1+10+3+1 = 43 ticks.
- count never exceeds duration−1; wrap-around is only via the phase advance.
- Reset mid-phase: immediate return to the reset values, no completion of yellow.

## Configuration
- PED_REQ_EN defined:
  - ped_req and walk ports exist.
  - ped_req=1 in any cycle sets ped_pend; ped_pend clears on entry to B_GREEN.
  - In A_GREEN with ped_pend=1 and count ≥ MIN_GREEN_T−1, the next tick advances to A_YELLOW.
  - walk=1 throughout a B_GREEN entered with ped_pend set; otherwise walk=0.
  - ped_req on the same clock as B_GREEN entry sets ped_pend again for the next cycle.
- PED_REQ_EN undefined: ped_req and walk ports are absent, and A_GREEN always runs the full GREEN_A_T.

## Structure
- Package traffic_pkg:
  - lamp encoding constants (LAMP_OFF/GREEN/YELLOW/RED)
  - phase enum (3-bit)
  - function returning a phase duration given parameters
- One sub-module, tl_phase_timer: the CNT_W counter with tick, clear and terminal-count output. The FSM, lamp decode and pedestrian latch live in the top.

## Test plan
- Reset then tick every clock → state 5 for 1 tick, A_GREEN at count 0, A_YELLOW after 25 ticks, period exactly 43 ticks; lamps match the decode at every phase.
- Tick every 4th clock → state and count hold between ticks; all phase lengths scale ×4 in clocks.
- Assert reset during B_YELLOW count=1 → same cycle: state=5, count=0, both lamps 3.
- Force illegal state 6 via bench backdoor → both lamps 3, next clock state=5, count=0.
- PED_REQ_EN, pulse ped_req at A_GREEN count=2 → A_YELLOW entered after count=7 (8 ticks green); walk=1 for all 10 B_GREEN ticks and 0 after.
- PED_REQ_EN, ped_req at A_GREEN count=20 → immediate next-tick A_YELLOW. Without the macro, the same stimulus is not applicable and A_GREEN lasts 25.
